pipeline_fg_scale_layers: RTL and testbench

PIPELINE_FG_SCALE_LAYERS -- requirements
Module: pipeline_fg_scale_layers

---
 rtl/pipeline_fg_scale_pkg.sv | 35 +++
 rtl/pipeline_fg_scale_axis.sv | 56 +++++
 rtl/pipeline_fg_scale_layers.sv | 231 +++++++++++++++++++++++
 tb/tb_pipeline_fg_scale_layers.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_fg_scale_pkg.sv
// ============================================================================
// Module      : pipeline_fg_scale_pkg
// Description : Shared types and fixed-point step constants for the
//               foreground scaling pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipeline_fg_scale_pkg;

    typedef enum logic [1:0] {
        MODE_FULL    = 2'd0,
        MODE_HALF    = 2'd1,
        MODE_QUARTER = 2'd2,
        MODE_CUSTOM  = 2'd3
    } fg_mode_e;

    localparam int c_frac_bits_default = 8;

    // Fixed-point steps expressed at the default fractional precision
    localparam int c_step_1p0 = 1 << c_frac_bits_default;
    localparam int c_step_2p0 = 2 << c_frac_bits_default;
    localparam int c_step_4p0 = 4 << c_frac_bits_default;

    // Re-expresses a default-precision step at another fractional precision
    function automatic int scale_step(input int step_default, input int frac_bits);
        if (frac_bits >= c_frac_bits_default)
            return step_default << (frac_bits - c_frac_bits_default);
        else
            return step_default >> (c_frac_bits_default - frac_bits);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipeline_fg_scale_axis.sv
// ============================================================================
// Module      : pipeline_fg_scale_axis
// Description : One axis of one layer: subtract offset (stage 1), multiply by
//               step and shift (stage 2), flag range of the full product.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_fg_scale_axis #(
    parameter int PRECISION  = 11,
    parameter int FRAC_BITS  = 8,
    parameter int RESOLUTION = 1920
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_advance,
    input  logic [PRECISION-1:0]           i_pixel,
    input  logic signed [PRECISION:0]      i_offset,
    input  logic [PRECISION+FRAC_BITS-1:0] i_step,
    output logic signed [PRECISION:0]      o_coord,
    output logic                           o_in_range
);

    localparam int DW = PRECISION + 2;
    localparam int SW = PRECISION + FRAC_BITS;
    localparam int PW = DW + SW + 1;
    localparam logic signed [PW-1:0] c_res = PW'(RESOLUTION);

    logic signed [DW-1:0] w_diff;
    logic signed [PW-1:0] w_prod;
    logic signed [DW-1:0] r_diff;
    logic [SW-1:0]        r_step;
    logic signed [PW-1:0] r_scaled;

    assign w_diff = $signed({2'b00, i_pixel}) - DW'(i_offset);
    // Step is zero-extended so the multiply stays signed
    assign w_prod = PW'(r_diff) * PW'($signed({1'b0, r_step}));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_diff   <= '0;
            r_step   <= '0;
            r_scaled <= '0;
        end else if (i_advance) begin
            r_diff   <= w_diff;
            r_step   <= i_step;
            r_scaled <= w_prod >>> FRAC_BITS;
        end
    end

    assign o_in_range = !r_scaled[PW-1] && (r_scaled < c_res);
    assign o_coord    = r_scaled[PRECISION:0];

endmodule

`default_nettype wire

// File: rtl/pipeline_fg_scale_layers.sv
// ============================================================================
// Module      : pipeline_fg_scale_layers
// Description : Multi-layer foreground coordinate scaler, 3-stage pipeline
//               with shadow/active configuration committed on frame_start.
//               Option macro: FG_SCALE_CUSTOM_STEP_EN (custom step mode).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_fg_scale_layers
    import pipeline_fg_scale_pkg::*;
#(
    parameter int RESOLUTION_X = 1920,
    parameter int RESOLUTION_Y = 1080,
    parameter int PRECISION    = 11,
    parameter int LAYERS       = 2,
    parameter int FRAC_BITS    = c_frac_bits_default
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              output_enable,
    input  logic                              frame_start,
    input  logic                              pixel_valid,
    input  logic [PRECISION-1:0]              pixel_x,
    input  logic [PRECISION-1:0]              pixel_y,
    input  logic                              cfg_we,
    input  logic [$clog2(LAYERS)-1:0]         cfg_layer,
    input  logic                              cfg_enable,
    input  logic [1:0]                        cfg_mode,
    input  logic [PRECISION+FRAC_BITS-1:0]    cfg_step_x,
    input  logic [PRECISION+FRAC_BITS-1:0]    cfg_step_y,
    input  logic signed [PRECISION:0]         cfg_offset_x,
    input  logic signed [PRECISION:0]         cfg_offset_y,
    output logic                              out_valid,
    output logic [LAYERS*(PRECISION+1)-1:0]   fg_pixel_x,
    output logic [LAYERS*(PRECISION+1)-1:0]   fg_pixel_y,
    output logic [LAYERS-1:0]                 fg_active,
    output logic                              any_active,
    output logic [$clog2(LAYERS)-1:0]         top_layer
);

    localparam int LW = $clog2(LAYERS);
    localparam int OW = PRECISION + 1;
    localparam int SW = PRECISION + FRAC_BITS;
    localparam logic [SW-1:0] c_step_one  = SW'(scale_step(c_step_1p0, FRAC_BITS));
    localparam logic [SW-1:0] c_step_two  = SW'(scale_step(c_step_2p0, FRAC_BITS));
    localparam logic [SW-1:0] c_step_four = SW'(scale_step(c_step_4p0, FRAC_BITS));

    logic [LAYERS-1:0]    r_shd_en;
    logic [LAYERS-1:0]    r_act_en;
    fg_mode_e             r_shd_mode  [LAYERS];
    fg_mode_e             r_act_mode  [LAYERS];
    logic signed [OW-1:0] r_shd_off_x [LAYERS];
    logic signed [OW-1:0] r_shd_off_y [LAYERS];
    logic signed [OW-1:0] r_act_off_x [LAYERS];
    logic signed [OW-1:0] r_act_off_y [LAYERS];
`ifdef FG_SCALE_CUSTOM_STEP_EN
    logic [SW-1:0]        r_shd_step_x [LAYERS];
    logic [SW-1:0]        r_shd_step_y [LAYERS];
    logic [SW-1:0]        r_act_step_x [LAYERS];
    logic [SW-1:0]        r_act_step_y [LAYERS];
`else
    logic                 w_unused_step;
    assign w_unused_step = ^{cfg_step_x, cfg_step_y};
`endif

    logic [SW-1:0]               w_step_x [LAYERS];
    logic [SW-1:0]               w_step_y [LAYERS];
    logic [LAYERS-1:0][OW-1:0]   w_coord_x;
    logic [LAYERS-1:0][OW-1:0]   w_coord_y;
    logic [LAYERS-1:0]           w_in_x;
    logic [LAYERS-1:0]           w_in_y;
    logic [LAYERS-1:0]           w_hit;
    logic [LW-1:0]               w_top;

    logic                        r_s1_valid;
    logic                        r_s2_valid;
    logic [LAYERS-1:0]           r_s1_en;
    logic [LAYERS-1:0]           r_s2_en;
    logic [LAYERS-1:0][OW-1:0]   r_fg_x;
    logic [LAYERS-1:0][OW-1:0]   r_fg_y;
    logic [LAYERS-1:0]           r_active;
    logic [LW-1:0]               r_top;
    logic                        r_out_valid;

    // Commit samples the shadow before this cycle's write lands
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shd_en <= '0;
            r_act_en <= '0;
            for (int n = 0; n < LAYERS; n++) begin
                r_shd_mode[n]  <= MODE_FULL;
                r_act_mode[n]  <= MODE_FULL;
                r_shd_off_x[n] <= '0;
                r_shd_off_y[n] <= '0;
                r_act_off_x[n] <= '0;
                r_act_off_y[n] <= '0;
`ifdef FG_SCALE_CUSTOM_STEP_EN
                r_shd_step_x[n] <= c_step_one;
                r_shd_step_y[n] <= c_step_one;
                r_act_step_x[n] <= c_step_one;
                r_act_step_y[n] <= c_step_one;
`endif
            end
        end else begin
            if (frame_start) begin
                r_act_en <= r_shd_en;
                for (int n = 0; n < LAYERS; n++) begin
                    r_act_mode[n]  <= r_shd_mode[n];
                    r_act_off_x[n] <= r_shd_off_x[n];
                    r_act_off_y[n] <= r_shd_off_y[n];
`ifdef FG_SCALE_CUSTOM_STEP_EN
                    r_act_step_x[n] <= r_shd_step_x[n];
                    r_act_step_y[n] <= r_shd_step_y[n];
`endif
                end
            end
            if (cfg_we && (int'(cfg_layer) < LAYERS)) begin
                r_shd_en[cfg_layer]    <= cfg_enable;
                r_shd_mode[cfg_layer]  <= fg_mode_e'(cfg_mode);
                r_shd_off_x[cfg_layer] <= cfg_offset_x;
                r_shd_off_y[cfg_layer] <= cfg_offset_y;
`ifdef FG_SCALE_CUSTOM_STEP_EN
                r_shd_step_x[cfg_layer] <= cfg_step_x;
                r_shd_step_y[cfg_layer] <= cfg_step_y;
`endif
            end
        end
    end

    always_comb begin
        for (int n = 0; n < LAYERS; n++) begin
            w_step_x[n] = c_step_one;
            w_step_y[n] = c_step_one;
            case (r_act_mode[n])
                MODE_HALF: begin
                    w_step_x[n] = c_step_two;
                    w_step_y[n] = c_step_two;
                end
                MODE_QUARTER: begin
                    w_step_x[n] = c_step_four;
                    w_step_y[n] = c_step_four;
                end
`ifdef FG_SCALE_CUSTOM_STEP_EN
                MODE_CUSTOM: begin
                    w_step_x[n] = r_act_step_x[n];
                    w_step_y[n] = r_act_step_y[n];
                end
`endif
                default: ;
            endcase
        end
    end

    // Offset and step are captured at stage-1 entry, so a commit never
    // alters pixels already in flight
    for (genvar n = 0; n < LAYERS; n++) begin : g_layer
        pipeline_fg_scale_axis #(
            .PRECISION  (PRECISION),
            .FRAC_BITS  (FRAC_BITS),
            .RESOLUTION (RESOLUTION_X)
        ) u_axis_x (
            .clk        (clk),
            .rst        (rst),
            .i_advance  (output_enable),
            .i_pixel    (pixel_x),
            .i_offset   (r_act_off_x[n]),
            .i_step     (w_step_x[n]),
            .o_coord    (w_coord_x[n]),
            .o_in_range (w_in_x[n])
        );

        pipeline_fg_scale_axis #(
            .PRECISION  (PRECISION),
            .FRAC_BITS  (FRAC_BITS),
            .RESOLUTION (RESOLUTION_Y)
        ) u_axis_y (
            .clk        (clk),
            .rst        (rst),
            .i_advance  (output_enable),
            .i_pixel    (pixel_y),
            .i_offset   (r_act_off_y[n]),
            .i_step     (w_step_y[n]),
            .o_coord    (w_coord_y[n]),
            .o_in_range (w_in_y[n])
        );
    end

    assign w_hit = {LAYERS{r_s2_valid}} & r_s2_en & w_in_x & w_in_y;

    always_comb begin
        w_top = '0;
        for (int n = 0; n < LAYERS; n++) begin
            if (w_hit[n]) w_top = LW'(n);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s2_valid  <= 1'b0;
            r_s1_en     <= '0;
            r_s2_en     <= '0;
            r_fg_x      <= '0;
            r_fg_y      <= '0;
            r_active    <= '0;
            r_top       <= '0;
            r_out_valid <= 1'b0;
        end else if (output_enable) begin
            r_s1_valid  <= pixel_valid;
            r_s2_valid  <= r_s1_valid;
            r_s1_en     <= r_act_en;
            r_s2_en     <= r_s1_en;
            r_fg_x      <= w_coord_x;
            r_fg_y      <= w_coord_y;
            r_active    <= w_hit;
            r_top       <= w_top;
            r_out_valid <= r_s2_valid;
        end
    end

    assign out_valid  = r_out_valid;
    assign fg_pixel_x = r_fg_x;
    assign fg_pixel_y = r_fg_y;
    assign fg_active  = r_active;
    assign any_active = |r_active;
    assign top_layer  = r_top;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_fg_scale_layers.sv
// ============================================================================
// Module      : tb_pipeline_fg_scale_layers
// Description : Self-checking bench with a transaction-level reference model
//               of the two-layer foreground scaler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipeline_fg_scale_layers;

    localparam int P  = 11;
    localparam int FB = 8;
    localparam int OW = P + 1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            output_enable = 1'b1;
    logic            frame_start = 1'b0;
    logic            pixel_valid = 1'b0;
    logic [P-1:0]    pixel_x = '0;
    logic [P-1:0]    pixel_y = '0;
    logic            cfg_we = 1'b0;
    logic [0:0]      cfg_layer = '0;
    logic            cfg_enable = 1'b0;
    logic [1:0]      cfg_mode = '0;
    logic [P+FB-1:0] cfg_step_x = '0;
    logic [P+FB-1:0] cfg_step_y = '0;
    logic [P:0]      cfg_offset_x = '0;
    logic [P:0]      cfg_offset_y = '0;
    logic            out_valid;
    logic [2*OW-1:0] fg_pixel_x;
    logic [2*OW-1:0] fg_pixel_y;
    logic [1:0]      fg_active;
    logic            any_active;
    logic [0:0]      top_layer;

    pipeline_fg_scale_layers dut (
        .clk(clk), .rst(rst), .output_enable(output_enable),
        .frame_start(frame_start), .pixel_valid(pixel_valid),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .cfg_we(cfg_we),
        .cfg_layer(cfg_layer), .cfg_enable(cfg_enable), .cfg_mode(cfg_mode),
        .cfg_step_x(cfg_step_x), .cfg_step_y(cfg_step_y),
        .cfg_offset_x(cfg_offset_x), .cfg_offset_y(cfg_offset_y),
        .out_valid(out_valid), .fg_pixel_x(fg_pixel_x), .fg_pixel_y(fg_pixel_y),
        .fg_active(fg_active), .any_active(any_active), .top_layer(top_layer)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             valid;
        logic [1:0]       act;
        logic [1:0][11:0] fx;
        logic [1:0][11:0] fy;
    } rec_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    rec_t q[$];
    rec_t exp_out;
    int   shd_en[2], shd_mode[2], shd_ox[2], shd_oy[2], shd_sx[2], shd_sy[2];
    int   act_en[2], act_mode[2], act_ox[2], act_oy[2], act_sx[2], act_sy[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int eff_step(input int mode, input int custom);
        case (mode)
            1: return 2 * 256;
            2: return 4 * 256;
`ifdef FG_SCALE_CUSTOM_STEP_EN
            3: return custom;
`endif
            default: return 256;
        endcase
    endfunction

    // Expected result for the pixel presented now, using the active config
    function automatic rec_t model_pixel();
        rec_t   r;
        longint fxl, fyl;
        r = '0;
        r.valid = pixel_valid;
        for (int n = 0; n < 2; n++) begin
            fxl = ((longint'(pixel_x) - act_ox[n]) * eff_step(act_mode[n], act_sx[n])) >>> 8;
            fyl = ((longint'(pixel_y) - act_oy[n]) * eff_step(act_mode[n], act_sy[n])) >>> 8;
            r.fx[n]  = fxl[11:0];
            r.fy[n]  = fyl[11:0];
            r.act[n] = pixel_valid && (act_en[n] != 0) && fxl >= 0 && fxl < 1920
                       && fyl >= 0 && fyl < 1080;
        end
        return r;
    endfunction

    task automatic model_edge();
        int l;
        if (rst) begin
            for (int n = 0; n < 2; n++) begin
                shd_en[n] = 0; shd_mode[n] = 0; shd_ox[n] = 0; shd_oy[n] = 0;
                shd_sx[n] = 256; shd_sy[n] = 256;
                act_en[n] = 0; act_mode[n] = 0; act_ox[n] = 0; act_oy[n] = 0;
                act_sx[n] = 256; act_sy[n] = 256;
            end
            q = {rec_t'('0), rec_t'('0)};
            exp_out = '0;
            return;
        end
        if (output_enable) begin
            q.push_back(model_pixel());
            exp_out = q.pop_front();
        end
        if (frame_start) begin
            act_en = shd_en; act_mode = shd_mode; act_ox = shd_ox;
            act_oy = shd_oy; act_sx = shd_sx; act_sy = shd_sy;
        end
        if (cfg_we) begin
            l = int'(cfg_layer);
            shd_en[l]   = int'(cfg_enable);
            shd_mode[l] = int'(cfg_mode);
            shd_ox[l]   = int'($signed(cfg_offset_x));
            shd_oy[l]   = int'($signed(cfg_offset_y));
            shd_sx[l]   = int'(cfg_step_x);
            shd_sy[l]   = int'(cfg_step_y);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        chk("out_valid", 32'(out_valid), 32'(exp_out.valid));
        chk("fg_active", 32'(fg_active), 32'(exp_out.act));
        chk("any_active", 32'(any_active), 32'(|exp_out.act));
        chk("top_layer", 32'(top_layer), 32'(exp_out.act[1]));
        if (exp_out.valid) begin
            for (int n = 0; n < 2; n++) begin
                chk("fg_x", 32'(fg_pixel_x[n*OW +: OW]), 32'(exp_out.fx[n]));
                chk("fg_y", 32'(fg_pixel_y[n*OW +: OW]), 32'(exp_out.fy[n]));
            end
        end
        cfg_we = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic write_cfg(input int layer, input int en, input int mode, input int ox,
                             input int oy, input int sx, input int sy, input bit fs);
        cfg_we = 1'b1; cfg_layer = 1'(layer); cfg_enable = 1'(en); cfg_mode = 2'(mode);
        cfg_offset_x = 12'(ox); cfg_offset_y = 12'(oy);
        cfg_step_x = 19'(sx); cfg_step_y = 19'(sy);
        frame_start = fs;
        cycle();
    endtask

    task automatic commit();
        frame_start = 1'b1;
        cycle();
    endtask

    // Present one pixel then let it drain to the output register
    task automatic probe(input int x, input int y);
        pixel_valid = 1'b1; pixel_x = 11'(x); pixel_y = 11'(y);
        cycle();
        pixel_valid = 1'b0;
        cycle();
        cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        cycle();
        cycle();
        chk("reset_out_valid", 32'(out_valid), 0);
        chk("reset_fg_x", 32'(fg_pixel_x), 0);
        rst = 1'b0;

        // Half scale, offset (100,50)
        write_cfg(0, 1, 1, 100, 50, 0, 0, 1'b0);
        commit();
        probe(300, 150);
        chk("half_fg0x", 32'(fg_pixel_x[11:0]), 400);
        chk("half_fg0y", 32'(fg_pixel_y[11:0]), 200);
        chk("half_active", 32'(fg_active), 1);
        probe(1059, 150);
        chk("edge_1059_x", 32'(fg_pixel_x[11:0]), 1918);
        chk("edge_1059_act", 32'(fg_active[0]), 1);
        probe(1060, 150);
        chk("edge_1060_x", 32'(fg_pixel_x[11:0]), 1920);
        chk("edge_1060_act", 32'(fg_active[0]), 0);
        probe(99, 150);
        chk("edge_99_x", 32'(fg_pixel_x[11:0]), 32'(12'hFFE));
        chk("edge_99_act", 32'(fg_active[0]), 0);

        // Two layers overlapping
        write_cfg(0, 1, 0, 0, 0, 0, 0, 1'b0);
        write_cfg(1, 1, 2, 10, 10, 0, 0, 1'b0);
        commit();
        probe(12, 12);
        chk("two_active", 32'(fg_active), 3);
        chk("two_top", 32'(top_layer), 1);
        chk("two_fg1x", 32'(fg_pixel_x[23:12]), 8);
        chk("two_fg1y", 32'(fg_pixel_y[23:12]), 8);

        // Shadow/active separation
        do_reset();
        write_cfg(0, 1, 0, 0, 0, 0, 0, 1'b0);
        probe(5, 5);
        chk("shadow_only", 32'(fg_active), 0);
        do_reset();
        write_cfg(0, 1, 0, 0, 0, 0, 0, 1'b1);
        probe(5, 5);
        chk("write_with_fs", 32'(fg_active), 0);
        commit();
        probe(5, 5);
        chk("after_fs", 32'(fg_active), 1);

        // Stall mid-stream
        for (int i = 0; i < 12; i++) begin
            pixel_valid = 1'b1; pixel_x = 11'(i * 7); pixel_y = 11'(i * 3);
            output_enable = !(i >= 4 && i < 9);
            cycle();
        end
        output_enable = 1'b1; pixel_valid = 1'b0;
        cycle(); cycle();

        // Reset mid-stream drops in-flight pixels
        pixel_valid = 1'b1; pixel_x = 11'd20; pixel_y = 11'd20;
        cycle();
        rst = 1'b1;
        cycle();
        chk("rst_mid_valid", 32'(out_valid), 0);
        chk("rst_mid_active", 32'(fg_active), 0);
        rst = 1'b0; pixel_valid = 1'b0;
        cycle(); cycle();
        chk("rst_drop_valid", 32'(out_valid), 0);

        // Custom step 1.5
        write_cfg(0, 1, 3, 0, 0, 'h180, 'h180, 1'b0);
        commit();
        probe(100, 0);
`ifdef FG_SCALE_CUSTOM_STEP_EN
        chk("custom_fgx", 32'(fg_pixel_x[11:0]), 150);
`else
        chk("custom_fgx", 32'(fg_pixel_x[11:0]), 100);
`endif

        // Randomised traffic against the model
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 149) == 0);
            output_enable = ($urandom_range(0, 7) != 0);
            pixel_valid = $urandom_range(0, 1);
            pixel_x = 11'($urandom_range(0, 2047));
            pixel_y = 11'($urandom_range(0, 1400));
            if ($urandom_range(0, 5) == 0) begin
                cfg_we = 1'b1;
                cfg_layer = 1'($urandom_range(0, 1));
                cfg_enable = ($urandom_range(0, 3) != 0);
                cfg_mode = 2'($urandom_range(0, 3));
                cfg_offset_x = 12'($urandom_range(0, 1200) - 400);
                cfg_offset_y = 12'($urandom_range(0, 1200) - 400);
                cfg_step_x = 19'($urandom_range(0, 1536));
                cfg_step_y = 19'($urandom_range(0, 1536));
            end
            frame_start = ($urandom_range(0, 7) == 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
